serial_tx_engine: RTL

//  Serial transmit engine driven by the memory-access controller's PARALLEL_LOAD/Tx_DATA

---
 rtl/serial_tx_engine.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/serial_tx_engine.sv
// UART-style serial transmitter: captures a parallel word and shifts it out as
// start bit, LSB-first data, optional even parity and stop bit, with registered outputs.
module serial_tx_engine #(
    parameter int DATA_WIDTH  = 8,
    parameter int CLK_PER_BIT = 4,
    parameter int PARITY_EN   = 0
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  PARALLEL_LOAD,
    input  logic                  Tx_DATA,
    input  logic [DATA_WIDTH-1:0] DIN,
    output logic                  TX,
    output logic                  Tx_DONE,
    output logic                  Tx_BUSY
);

    localparam int CW = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLK_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    function automatic logic even_parity(input logic [DATA_WIDTH-1:0] word);
        return ^word;
    endfunction

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] load_q, load_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  par_q, par_d;
    logic [CW-1:0]         baud_q, baud_d;
    logic [BW-1:0]         bit_q, bit_d;
    logic                  tx_q, tx_d;
    logic                  done_q, done_d;
    logic                  busy_q, busy_d;
    logic [DATA_WIDTH-1:0] word_s;
    logic                  baud_end_s;

    // State, datapath and output registers
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= ST_IDLE;
            load_q  <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            baud_q  <= '0;
            bit_q   <= '0;
            tx_q    <= 1'b1;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            load_q  <= load_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state logic; outputs are derived from the next state so they register with it
    always_comb begin
        state_d    = state_q;
        load_d     = load_q;
        shift_d    = shift_q;
        par_d      = par_q;
        baud_d     = baud_q;
        bit_d      = bit_q;
        word_s     = load_q;
        baud_end_s = (baud_q == BAUD_LAST);

        case (state_q)
            ST_IDLE: begin
                baud_d = '0;
                bit_d  = '0;
                if (PARALLEL_LOAD) begin
                    load_d = DIN;
                    word_s = DIN;
                end else begin
                    load_d = load_q;
                    word_s = load_q;
                end
                if (Tx_DATA) begin
                    shift_d = word_s;
                    par_d   = even_parity(word_s);
                    state_d = ST_START;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (baud_end_s) begin
                    baud_d  = '0;
                    state_d = ST_DATA;
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
            ST_DATA: begin
                if (baud_end_s) begin
                    baud_d = '0;
                    if (bit_q == BIT_LAST) begin
                        bit_d   = '0;
                        state_d = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                    end else begin
                        shift_d = shift_q >> 1;
                        bit_d   = bit_q + BW'(1);
                    end
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
            ST_PARITY: begin
                if (baud_end_s) begin
                    baud_d  = '0;
                    state_d = ST_STOP;
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
            ST_STOP: begin
                if (baud_end_s) begin
                    baud_d  = '0;
                    state_d = ST_IDLE;
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                baud_d  = '0;
                bit_d   = '0;
            end
        endcase

        case (state_d)
            ST_IDLE:   tx_d = 1'b1;
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_d[0];
            ST_PARITY: tx_d = par_d;
            ST_STOP:   tx_d = 1'b1;
            default:   tx_d = 1'b1;
        endcase
        done_d = (state_d == ST_IDLE);
        busy_d = ~done_d;
    end

    assign TX      = tx_q;
    assign Tx_DONE = done_q;
    assign Tx_BUSY = busy_q;

endmodule
